mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the rs/rt operand pair read from the register file and performs MULT, MULTU, DIV and DIVU over DATA_WIDTH cycles.
- Holds the results in HI/LO, which the datapath returns to the register file write port for MFHI/MFLO.
- Also supports direct MTHI/MTLO writes.

Parameters:
- DATA_WIDTH, 32, operand width and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  DATA_WIDTH  multiplicand/dividend (register file reg1).
- rt_data  input  DATA_WIDTH  multiplier/divisor (register file reg2).
- mthi  input  1  write rs_data into HI.
- mtlo  input  1  write rs_data into LO.
- flush  input  1  abort the in-flight operation; HI/LO are left unchanged.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse in the cycle after HI/LO are updated by an operation.

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. A reset during RUN/FINISH aborts and discards the operation.
- Priority below reset: flush > start > mthi/mtlo.
- FSM states: IDLE, RUN, FINISH.
- IDLE, start=1 at edge N:
  - latch op, signs, abs(rs_data), abs(rt_data) (abs applied for signed ops only);
  - clear partial registers, counter=0, state=RUN, busy=1.
- RUN:
  - one shift-add (multiply) or restoring shift-subtract (divide) step per edge, counter+1;
  - at the edge where counter reaches DATA_WIDTH-1, i.e. edge N+DATA_WIDTH, go to FINISH.
- FINISH, edge N+DATA_WIDTH+1:
  - apply sign correction and write HI/LO;
  - state=IDLE, busy=0, done=1 for exactly this following cycle.
- Latency: busy is high for DATA_WIDTH+1 cycles (33 by default).
- A new start is accepted in the done cycle.
- Result mapping:
  - MULT/MULTU: {hi,lo} = full 2*DATA_WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Signed rules:
  - product is negated iff operand signs differ;
  - quotient is negated iff signs differ (truncation toward zero);
  - remainder takes the sign of the dividend.
- Signed overflow, -2^(W-1) / -1: lo=0x80000000, hi=0. This falls out of the abs/unsigned datapath; no special casing.
- Divide by zero (DIV or DIVU): hi=rs_data, lo=all ones. Takes the full latency; no exception.
- start while busy: ignored; the in-flight operation and its latched operands are unaffected.
- mthi/mtlo:
  - while busy: ignored;
  - while idle without start: the register is written at the next edge, and mthi and mtlo together both write rs_data;
  - together with start: ignored.
- flush: in RUN or FINISH, return to IDLE at the next edge with busy=0, done=0, and HI/LO unchanged. In IDLE, flush suppresses start and mthi/mtlo that cycle.
- hi/lo are registered outputs and hold their values until the next completed operation, mthi/mtlo write, or reset.
- Operand inputs may change freely after the start edge.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 busy cycles, done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A second start issued at cycle 10 is ignored and the result is unchanged.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 -> hi=100, lo=0xFFFFFFFF after the full 33-cycle latency.
- MTHI 0x1234 and MTLO 0x5678 in consecutive idle cycles -> hi=0x1234, lo=0x5678 one edge after each. MTHI asserted during busy -> hi unchanged.
- Start DIVU 50/3 with hi=0xAA, lo=0xBB, then flush at cycle 12 -> busy=0 next cycle, no done, hi/lo stay 0xAA/0xBB. Repeat with reset instead of flush -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU via shift-add, DIV/DIVU via
// restoring division on magnitudes, with sign correction applied on the final cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  counter_q, counter_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div_zero_q, div_zero_d;
  logic [W-1:0]      opb_q, opb_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      work_q, work_d;
  logic [W-1:0]      hi_q, hi_d;
  logic [W-1:0]      lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              rs_neg, rt_neg;
  logic [W-1:0]      rs_abs, rt_abs;
  logic [W:0]        mul_sum;
  logic [W:0]        div_shift;
  logic              div_ge;
  logic [W-1:0]      div_diff;
  logic [2*W-1:0]    product;
  logic [W-1:0]      quot;
  logic [W-1:0]      rem;

  // Operand magnitudes and signs; op[0]=0 selects the signed variants.
  always_comb begin
    rs_neg = ~op[0] & rs_data[W-1];
    rt_neg = ~op[0] & rt_data[W-1];
    if (rs_neg) begin
      rs_abs = -rs_data;
    end else begin
      rs_abs = rs_data;
    end
    if (rt_neg) begin
      rt_abs = -rt_data;
    end else begin
      rt_abs = rt_data;
    end
  end

  // One iteration step for each operation plus the sign-corrected results.
  always_comb begin
    if (work_q[0]) begin
      mul_sum = {1'b0, acc_q} + {1'b0, opb_q};
    end else begin
      mul_sum = {1'b0, acc_q};
    end
    // The partial remainder stays below the divisor, so the difference fits in W bits.
    div_shift = {acc_q, work_q[W-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift[W-1:0] - opb_q;

    product = {acc_q, work_q};
    if (neg_res_q) begin
      product = -product;
    end else begin
      product = {acc_q, work_q};
    end
    quot = work_q;
    if (div_zero_q) begin
      quot = '1;
    end else if (neg_res_q) begin
      quot = -work_q;
    end else begin
      quot = work_q;
    end
    if (neg_rem_q) begin
      rem = -acc_q;
    end else begin
      rem = acc_q;
    end
  end

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    work_d     = work_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          busy_d = 1'b0;
        end else if (start) begin
          is_div_d   = op[1];
          neg_res_d  = rs_neg ^ rt_neg;
          neg_rem_d  = rs_neg;
          div_zero_d = op[1] & (rt_data == '0);
          if (op[1]) begin
            work_d = rs_abs;
            opb_d  = rt_abs;
          end else begin
            work_d = rt_abs;
            opb_d  = rs_abs;
          end
          acc_d     = '0;
          counter_d = '0;
          state_d   = RUN;
          busy_d    = 1'b1;
        end else begin
          if (mthi) begin
            hi_d = rs_data;
          end else begin
            hi_d = hi_q;
          end
          if (mtlo) begin
            lo_d = rs_data;
          end else begin
            lo_d = lo_q;
          end
        end
      end

      RUN: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            if (div_ge) begin
              acc_d  = div_diff;
              work_d = {work_q[W-2:0], 1'b1};
            end else begin
              acc_d  = div_shift[W-1:0];
              work_d = {work_q[W-2:0], 1'b0};
            end
          end else begin
            acc_d  = mul_sum[W:1];
            work_d = {mul_sum[0], work_q[W-1:1]};
          end
          counter_d = counter_q + CNT_W'(1);
          if (counter_q == LAST_CNT) begin
            state_d = FINISH;
          end else begin
            state_d = RUN;
          end
        end
      end

      FINISH: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            hi_d = product[2*W-1:W];
            lo_d = product[W-1:0];
          end
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      work_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      work_q     <= work_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
